// File: rtl/partialproduct_accum_pkg.sv
// Shared types and sizing helpers for the partial-product accumulator.
package pp_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        PP_IDLE  = 2'd0,
        PP_ACCUM = 2'd1,
        PP_DONE  = 2'd2
    } pp_state_e;

    // Wide enough to hold the values 0..num_pp.
    function automatic int count_width(input int num_pp);
        return (num_pp < 1) ? 1 : $clog2(num_pp + 1);
    endfunction

endpackage

// File: rtl/partialproduct_accum_if.sv
// Partial-product input and held-result output handshakes of the accumulator.
interface partialproduct_accum_if #(
    parameter int DATA_WIDTH = pp_pkg::DEFAULT_DATA_WIDTH
);
    import pp_pkg::*;

    // A transfer happens on a rising edge where valid && ready; the sender holds
    // data stable while valid is high and ready is low.
    logic                      pp_valid;
    logic                      pp_ready;
    logic [2*DATA_WIDTH-1:0]   pp_data;
    logic                      pp_cin;
    logic                      result_valid;
    logic                      result_ready;
    logic [2*DATA_WIDTH-1:0]   result_data;
    logic                      result_cout;

    modport master (
        output pp_valid, pp_data, pp_cin, result_ready,
        input  pp_ready, result_valid, result_data, result_cout
    );

    modport slave (
        input  pp_valid, pp_data, pp_cin, result_ready,
        output pp_ready, result_valid, result_data, result_cout
    );

endinterface

// File: rtl/partialproduct_accum_cadd.sv
// Combinational adder with carry-in and carry-out.
module pp_cadd #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] full;

    assign full = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    assign sum  = full[WIDTH-1:0];
    assign cout = full[WIDTH];

endmodule

// File: rtl/partialproduct_accum.sv
// Accumulates NUM_PP partial products with carry-in into a double-width sum and
// presents the product, plus a sticky carry-out, on a held result handshake.
module partialproduct_accum
    import pp_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int NUM_PP     = DATA_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    partialproduct_accum_if.slave  bus,
    output pp_state_e              state
);

    localparam int W2 = 2 * DATA_WIDTH;
    localparam int CW = count_width(NUM_PP);

    pp_state_e         state_q;
    pp_state_e         next_state;
    logic [W2-1:0]     acc_q;
    logic              carry_q;
    logic [CW-1:0]     count_q;
    logic              ready_int;
    logic              accept;
    logic              last_pp;
    logic [W2-1:0]     add_a;
    logic [W2-1:0]     sum;
    logic              cout;

    assign accept = bus.pp_valid && ready_int;

    // count is stale in IDLE, so the first product term is judged on NUM_PP alone.
    assign last_pp = (state_q == PP_IDLE) ? (NUM_PP == 1)
                                          : (count_q == CW'(NUM_PP - 1));

    // Starting a product discards the previous sum rather than adding to it.
    assign add_a = (state_q == PP_IDLE) ? '0 : acc_q;

    pp_cadd #(.WIDTH(W2)) u_cadd (
        .a    (add_a),
        .b    (bus.pp_data),
        .cin  (bus.pp_cin),
        .sum  (sum),
        .cout (cout)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= PP_IDLE;
        end else begin
            state_q <= next_state;
        end
    end

    always_comb begin
        next_state = state_q;
        if (clear) begin
            next_state = PP_IDLE;
        end else begin
            case (state_q)
                PP_IDLE, PP_ACCUM: if (accept) next_state = last_pp ? PP_DONE : PP_ACCUM;
                PP_DONE:           if (bus.result_ready) next_state = PP_IDLE;
                default:           next_state = PP_IDLE;
            endcase
        end
    end

    always_comb begin
        ready_int        = (state_q != PP_DONE);
        bus.pp_ready     = ready_int;
        bus.result_valid = (state_q == PP_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q   <= '0;
            carry_q <= 1'b0;
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (accept) begin
            acc_q   <= sum;
            carry_q <= ((state_q == PP_ACCUM) ? carry_q : 1'b0) | cout;
            count_q <= (state_q == PP_IDLE) ? CW'(1) : count_q + 1'b1;
        end
    end

    assign bus.result_data = acc_q;
    assign bus.result_cout = carry_q;
    assign state           = state_q;

endmodule

// File: tb/tb_partialproduct_accum.sv
// Directed bench for partialproduct_accum: NUM_PP=4 and NUM_PP=1 instances.
module tb_partialproduct_accum;
    import pp_pkg::*;

    logic clk;
    logic reset;
    logic clear_a;
    logic clear_b;
    pp_state_e state_a;
    pp_state_e state_b;

    int total = 0;
    int bad   = 0;

    logic [16:0] exp_q[$];
    logic [16:0] exp_b_q[$];

    partialproduct_accum_if #(.DATA_WIDTH(8)) bus_a ();
    partialproduct_accum_if #(.DATA_WIDTH(8)) bus_b ();

    partialproduct_accum #(.DATA_WIDTH(8), .NUM_PP(4)) dut_a (
        .clk   (clk),
        .reset (reset),
        .clear (clear_a),
        .bus   (bus_a.slave),
        .state (state_a)
    );

    partialproduct_accum #(.DATA_WIDTH(8), .NUM_PP(1)) dut_b (
        .clk   (clk),
        .reset (reset),
        .clear (clear_b),
        .bus   (bus_b.slave),
        .state (state_b)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // monitors: pop on every completed result handshake
    always @(negedge clk) begin
        if (!reset && !clear_a && bus_a.result_valid && bus_a.result_ready) begin
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL result_a_unexpected: got %h expected none",
                         {bus_a.result_cout, bus_a.result_data});
            end else begin
                check("result_a", {15'd0, bus_a.result_cout, bus_a.result_data}, {15'd0, exp_q.pop_front()});
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && !clear_b && bus_b.result_valid && bus_b.result_ready) begin
            if (exp_b_q.size() == 0) begin
                total++; bad++;
                $display("FAIL result_b_unexpected: got %h expected none",
                         {bus_b.result_cout, bus_b.result_data});
            end else begin
                check("result_b", {15'd0, bus_b.result_cout, bus_b.result_data}, {15'd0, exp_b_q.pop_front()});
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pp(input logic [15:0] d, input logic c);
        int guard;
        guard = 0;
        bus_a.pp_valid = 1'b1;
        bus_a.pp_data  = d;
        bus_a.pp_cin   = c;
        @(negedge clk);
        while (!bus_a.pp_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!bus_a.pp_ready) begin
            total++; bad++;
            $display("FAIL pp_ready_timeout: got 0 expected 1");
        end
        tick();
        bus_a.pp_valid = 1'b0;
        bus_a.pp_cin   = 1'b0;
    endtask

    task automatic send4(input logic [15:0] d0, input logic [15:0] d1,
                         input logic [15:0] d2, input logic [15:0] d3, input logic c0);
        send_pp(d0, c0);
        send_pp(d1, 1'b0);
        send_pp(d2, 1'b0);
        send_pp(d3, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        check({tag, "_pp_ready"},     {31'd0, bus_a.pp_ready},     32'd1);
        check({tag, "_result_valid"}, {31'd0, bus_a.result_valid}, 32'd0);
        check({tag, "_result_data"},  {16'd0, bus_a.result_data},  32'd0);
        check({tag, "_result_cout"},  {31'd0, bus_a.result_cout},  32'd0);
    endtask

    initial begin
        reset = 1'b1;
        clear_a = 1'b0;
        clear_b = 1'b0;
        bus_a.pp_valid = 1'b0; bus_a.pp_data = '0; bus_a.pp_cin = 1'b0; bus_a.result_ready = 1'b1;
        bus_b.pp_valid = 1'b0; bus_b.pp_data = '0; bus_b.pp_cin = 1'b0; bus_b.result_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check_reset_outputs("reset");
        check("reset_b_valid", {31'd0, bus_b.result_valid}, 32'd0);
        tick();

        // basic sum, then latency: DONE is visible right after the 4th accept
        exp_q.push_back({1'b0, 16'h000F});
        send4(16'h0001, 16'h0002, 16'h0004, 16'h0008, 1'b0);
        @(negedge clk);
        check("latency_valid", {31'd0, bus_a.result_valid}, 32'd1);
        tick();

        // overflow: sticky carry
        exp_q.push_back({1'b1, 16'h0000});
        send4(16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 1'b0);
        tick();

        // carry-in on the first term
        exp_q.push_back({1'b0, 16'h0100});
        send4(16'h00FF, 16'h0000, 16'h0000, 16'h0000, 1'b1);
        tick();

        // backpressure: result held, nothing absorbed
        bus_a.result_ready = 1'b0;
        exp_q.push_back({1'b0, 16'h3334});
        send4(16'h1111, 16'h2222, 16'h0001, 16'h0000, 1'b0);
        bus_a.pp_valid = 1'b1;
        bus_a.pp_data  = 16'hAAAA;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_pp_ready",     {31'd0, bus_a.pp_ready},     32'd0);
            check("bp_result_valid", {31'd0, bus_a.result_valid}, 32'd1);
            check("bp_result_data",  {16'd0, bus_a.result_data},  32'h3334);
            tick();
        end
        bus_a.pp_valid = 1'b0;
        bus_a.result_ready = 1'b1;
        tick();
        @(negedge clk);
        check("bp_release_state", {30'd0, state_a}, {30'd0, PP_IDLE});
        check("bp_release_ready", {31'd0, bus_a.pp_ready}, 32'd1);
        tick();

        // clear mid-product drops the concurrent partial product
        send_pp(16'h0100, 1'b0);
        send_pp(16'h0200, 1'b0);
        bus_a.pp_valid = 1'b1;
        bus_a.pp_data  = 16'h0400;
        clear_a = 1'b1;
        tick();
        clear_a = 1'b0;
        bus_a.pp_valid = 1'b0;
        @(negedge clk);
        check("clear_state", {30'd0, state_a}, {30'd0, PP_IDLE});
        check("clear_valid", {31'd0, bus_a.result_valid}, 32'd0);
        tick();
        exp_q.push_back({1'b0, 16'h0040});
        send4(16'h0010, 16'h0010, 16'h0010, 16'h0010, 1'b0);
        tick();

        // clear in DONE discards the result even with result_ready high
        bus_a.result_ready = 1'b0;
        send4(16'h0001, 16'h0001, 16'h0001, 16'h0001, 1'b0);
        bus_a.result_ready = 1'b1;
        clear_a = 1'b1;
        tick();
        clear_a = 1'b0;
        @(negedge clk);
        check("clear_done_valid", {31'd0, bus_a.result_valid}, 32'd0);
        check("clear_done_state", {30'd0, state_a}, {30'd0, PP_IDLE});
        tick();

        // reset during ACCUM
        send_pp(16'h5555, 1'b0);
        send_pp(16'h5555, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_outputs("mid_reset");
        tick();
        exp_q.push_back({1'b0, 16'h0004});
        send4(16'h0001, 16'h0001, 16'h0001, 16'h0001, 1'b0);
        tick();

        // NUM_PP=1 instance
        exp_b_q.push_back({1'b0, 16'h1234});
        bus_b.pp_valid = 1'b1;
        bus_b.pp_data  = 16'h1234;
        tick();
        bus_b.pp_valid = 1'b0;
        @(negedge clk);
        check("b_latency_valid", {31'd0, bus_b.result_valid}, 32'd1);
        check("b_result_data",   {16'd0, bus_b.result_data},  32'h1234);
        tick();
        tick();
        tick();

        check("queue_a_drained", exp_q.size(), 32'd0);
        check("queue_b_drained", exp_b_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
